// File: rtl/keycode_pkg.sv
// Shared types for the keycode event queue: game actions, HID keycodes,
// the queued event record and the keycode-to-action map.
package keycode_pkg;

  typedef enum logic [2:0] {
    ACT_NONE  = 3'd0,
    ACT_LEFT  = 3'd1,
    ACT_RIGHT = 3'd2,
    ACT_JUMP  = 3'd3,
    ACT_DOWN  = 3'd4
  } action_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REL  = 2'd1,
    ST_PRS  = 2'd2
  } state_e;

  localparam logic [7:0] KC_A     = 8'h04;
  localparam logic [7:0] KC_D     = 8'h07;
  localparam logic [7:0] KC_W     = 8'h1A;
  localparam logic [7:0] KC_SPACE = 8'h2C;
  localparam logic [7:0] KC_S     = 8'h16;

  typedef struct packed {
    action_e action;
    logic    press;
  } event_t;

  function automatic action_e map_keycode(input logic [7:0] kc);
    action_e act;
    case (kc)
      KC_A:     act = ACT_LEFT;
      KC_D:     act = ACT_RIGHT;
      KC_W:     act = ACT_JUMP;
      KC_SPACE: act = ACT_JUMP;
      KC_S:     act = ACT_DOWN;
      default:  act = ACT_NONE;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// First-word fall-through FIFO of press/release events. A push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module event_fifo
  import keycode_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  event_t                 wdata,
  output event_t                 rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_ZERO = (PW+1)'(0);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_ZERO = PW'(0);

  event_t        mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop  = pop && (cnt_q != CNT_ZERO);
    do_push = push && ((cnt_q != CNT_FULL) || do_pop);
    wr_d    = do_push ? (wr_q + PTR_ONE) : wr_q;
    rd_d    = do_pop ? (rd_q + PTR_ONE) : rd_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= PTR_ZERO;
      rd_q  <= PTR_ZERO;
      cnt_q <= CNT_ZERO;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; the head is only meaningful while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_q];
  assign full  = (cnt_q == CNT_FULL);
  assign empty = (cnt_q == CNT_ZERO);
  assign count = cnt_q;

endmodule

// File: rtl/keycode_event_queue.sv
// Debounces the raw USB keycode, maps it to a game action and queues ordered
// release/press events; also tracks the held action and its frame count.
module keycode_event_queue
  import keycode_pkg::*;
#(
  parameter int STABLE_CYCLES = 50000,
  parameter int FIFO_DEPTH    = 4,
  parameter int HOLD_MAX      = 255
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       frame_tick,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [2:0] evt_action,
  output logic       evt_press,
  output logic [2:0] held_action,
  output logic [7:0] hold_frames
);

  localparam int SC_W = $clog2(STABLE_CYCLES + 1);
  localparam int FC_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [SC_W-1:0] SC_MAX   = SC_W'(STABLE_CYCLES - 1);
  localparam logic [SC_W-1:0] SC_ONE   = SC_W'(1);
  localparam logic [SC_W-1:0] SC_ZERO  = SC_W'(0);
  localparam logic [FC_W-1:0] FC_ZERO  = FC_W'(0);
  localparam logic [7:0]      HOLD_TOP = 8'(HOLD_MAX);

  logic [7:0]      kc_q, kc_d, cand_q, cand_d, stable_q, stable_d;
  logic [SC_W-1:0] cnt_q, cnt_d;
  state_e          state_q, state_d;
  action_e         held_q, held_d, old_q, old_d, a_old_s, a_new_s;
  logic [7:0]      hold_q, hold_d;
  logic            commit_s, pop_s, push_s, space_s;
  event_t          push_data_s, head_s;
  logic            fifo_full_s, fifo_empty_s;
  logic [FC_W-1:0] fifo_count_s;

  // Input stage: candidate follows kc_q, counter measures how long it has been steady.
  always_comb begin
    kc_d = keycode;
    if (kc_q != cand_q) begin
      cand_d = kc_q;
      cnt_d  = SC_ZERO;
    end else if (cnt_q != SC_MAX) begin
      cand_d = cand_q;
      cnt_d  = cnt_q + SC_ONE;
    end else begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
    end
  end

  always_comb begin
    a_old_s  = map_keycode(stable_q);
    a_new_s  = map_keycode(cand_q);
    commit_s = (cnt_q == SC_MAX) && (cand_q != stable_q) && (state_q == ST_IDLE);
    pop_s    = evt_valid && evt_ready;
    space_s  = !fifo_full_s || pop_s;
  end

  // Commit and release/press sequencing; a stalled push simply holds the state.
  always_comb begin
    state_d     = state_q;
    stable_d    = stable_q;
    held_d      = held_q;
    old_d       = old_q;
    push_s      = 1'b0;
    push_data_s = '{action: ACT_NONE, press: 1'b0};
    case (state_q)
      ST_IDLE: begin
        if (commit_s) begin
          stable_d = cand_q;
          held_d   = a_new_s;
          old_d    = a_old_s;
          if (a_old_s == a_new_s) begin
            state_d = ST_IDLE;
          end else if (a_old_s != ACT_NONE) begin
            state_d = ST_REL;
          end else begin
            state_d = ST_PRS;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REL: begin
        push_s      = 1'b1;
        push_data_s = '{action: old_q, press: 1'b0};
        if (!space_s) begin
          state_d = ST_REL;
        end else if (held_q != ACT_NONE) begin
          state_d = ST_PRS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRS: begin
        push_s      = 1'b1;
        push_data_s = '{action: held_q, press: 1'b1};
        if (space_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_PRS;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // An action-changing commit outranks a coincident frame_tick.
  always_comb begin
    if (commit_s && (a_old_s != a_new_s)) begin
      hold_d = 8'd0;
    end else if (held_q == ACT_NONE) begin
      hold_d = 8'd0;
    end else if (frame_tick && (hold_q != HOLD_TOP)) begin
      hold_d = hold_q + 8'd1;
    end else begin
      hold_d = hold_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      kc_q     <= 8'h00;
      cand_q   <= 8'h00;
      cnt_q    <= SC_ZERO;
      stable_q <= 8'h00;
      state_q  <= ST_IDLE;
      held_q   <= ACT_NONE;
      old_q    <= ACT_NONE;
      hold_q   <= 8'd0;
    end else begin
      kc_q     <= kc_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      state_q  <= state_d;
      held_q   <= held_d;
      old_q    <= old_d;
      hold_q   <= hold_d;
    end
  end

  event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (Clk),
    .rst   (Reset),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (push_data_s),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  always_comb begin
    evt_valid = (fifo_count_s != FC_ZERO);
    if (fifo_empty_s) begin
      evt_action = 3'd0;
      evt_press  = 1'b0;
    end else begin
      evt_action = head_s.action;
      evt_press  = head_s.press;
    end
  end

  assign held_action = held_q;
  assign hold_frames = hold_q;

endmodule
